// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, 8N1 frame constants and
// the baud divisor helper used by both the receiver and the transmitter.
package uart_pkg;

  // Legacy-compatible numeric state codes
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    DATA      = ST_DATA,
    STOP      = ST_STOP,
    WAIT_HIGH = ST_WAIT_HIGH
  } uart_state_t;

  // 8N1 frame shape
  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

  // Clock cycles per serial bit (integer division, truncating)
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to
// 1 so a reset never looks like a start edge on the idle-high line.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta_reg;
  logic sync_reg;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
    end
  end

  assign dout = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling. Each good byte is presented on
// data with a one-cycle dataReady strobe; a low stop bit gives a one-cycle
// frameError strobe and the receiver then waits for the line to go high.
// Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 vote around every
// sample point, decision one cycle after the nominal sample).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       dataReady,
  output logic       frameError
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF         = CLKS_PER_BIT / 2;

`ifdef UART_RX_MAJORITY_EN
  // The vote needs the sample after the nominal point, so the first decision
  // (and with it the whole frame schedule) slips by one cycle.
  localparam int START_WAIT = HALF + 1;
`else
  localparam int START_WAIT = HALF;
`endif

  localparam int CNT_W = (CLKS_PER_BIT < 4) ? 2 : $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(START_WAIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_rate
    $error("uart_rx: CLK_HZ/BAUD must give at least 4 clocks per bit");
  end

  logic                      rx_s;
  logic                      sample_bit;
  uart_state_t               state_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic [BIT_W-1:0]          bit_idx_reg;
  logic [UART_DATA_BITS-1:0] shifter_reg;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (rx),
    .dout  (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic rx_d1_reg;
  logic rx_d2_reg;

  // History of the synchronized line for the 2-of-3 vote
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_d1_reg <= 1'b1;
      rx_d2_reg <= 1'b1;
    end else begin
      rx_d1_reg <= rx_s;
      rx_d2_reg <= rx_d1_reg;
    end
  end

  assign sample_bit = (rx_s & rx_d1_reg) | (rx_s & rx_d2_reg) | (rx_d1_reg & rx_d2_reg);
`else
  assign sample_bit = rx_s;
`endif

  // Frame sequencer: bit timing, data capture and result strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shifter_reg <= '0;
      data        <= 8'h00;
      dataReady   <= 1'b0;
      frameError  <= 1'b0;
    end else begin
      dataReady  <= 1'b0;
      frameError <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rx_s == UART_START_LEVEL) begin
            cnt_reg   <= '0;
            state_reg <= START;
          end
        end
        START: begin
          if (cnt_reg == CNT_START) begin
            cnt_reg <= '0;
            // A start bit that is gone by mid-bit was only a glitch
            if (sample_bit == UART_START_LEVEL) begin
              bit_idx_reg <= '0;
              state_reg   <= DATA;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg                  <= '0;
            shifter_reg[bit_idx_reg] <= sample_bit;
            if (bit_idx_reg == LAST_BIT) begin
              state_reg <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            if (sample_bit == UART_STOP_LEVEL) begin
              data      <= shifter_reg;
              dataReady <= 1'b1;
              state_reg <= IDLE;
            end else begin
              frameError <= 1'b1;
              state_reg  <= WAIT_HIGH;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must not be read as a string of frames
          if (rx_s == UART_STOP_LEVEL) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: a vector table of frames, hand
// sequences for glitch, back-to-back and mid-frame reset, then random frames
// compared against expected (cycle, byte) pairs.
module tb_uart_rx;

  localparam int CLK_HZ = 1600;
  localparam int BAUD   = 100;
  localparam int CPB    = 16;
  localparam int FRAME  = 10 * CPB;

`ifdef UART_RX_MAJORITY_EN
  localparam int         LAT        = 2 + 8 + 144 + 1 + 1;
  localparam logic [7:0] GLITCH_EXP = 8'h3A;
`else
  localparam int         LAT        = 2 + 8 + 144 + 1;
  localparam logic [7:0] GLITCH_EXP = 8'h3E;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       dataReady;
  logic       frameError;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .dataReady  (dataReady),
    .frameError (frameError)
  );

  // Strobe log, sampled on the falling edge
  int         ev_cyc[$];
  bit         ev_rdy[$];
  logic [7:0] ev_data[$];
  bit         prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_strobe = 1'b0;
    end else begin
      if (dataReady || frameError) begin
        ev_cyc.push_back(cyc);
        ev_rdy.push_back(dataReady);
        ev_data.push_back(data);
        checks++;
        if ((dataReady && frameError) || prev_strobe) begin
          failures++;
          $display("FAIL strobe_shape: cycle %0d dataReady=%0b frameError=%0b prev=%0b required single exclusive pulse",
                   cyc, dataReady, frameError, prev_strobe);
        end
      end
      prev_strobe = dataReady || frameError;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    ev_cyc.delete();
    ev_rdy.delete();
    ev_data.delete();
  endtask

  // Drive one frame starting at the current falling edge; ends 10 bits later
  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input int glitch_bit, output int fall);
    rx   = 1'b0;
    fall = cyc;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      if (k == glitch_bit) begin
        repeat (CPB / 2) @(negedge clk);
        rx = ~rx;
        @(negedge clk);
        rx = ~rx;
        repeat (CPB / 2 - 1) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
    end
    rx = stop_val;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic expect_one(input string name, input int fall, input bit rdy,
                            input logic [7:0] exp_ev, input logic [7:0] exp_port);
    check({name, "_count"}, ev_cyc.size(), 1);
    if (ev_cyc.size() >= 1) begin
      check({name, "_latency"}, ev_cyc[0] - fall, LAT);
      check({name, "_kind"}, int'(ev_rdy[0]), int'(rdy));
      if (rdy) check({name, "_evdata"}, ev_data[0], exp_ev);
    end
    check({name, "_data"}, data, exp_port);
    $display("%s: fall=%0d strobes=%0d data=0x%02h", name, fall, ev_cyc.size(), data);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    int         glitch;
    bit         exp_rdy;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       vecs[8];
  int         f1, f2;
  logic [7:0] rb;
  int         exp_cyc[$];
  logic [7:0] exp_b[$];

  initial begin
    vecs[0] = '{8'h3A, 1'b1, -1, 1'b1, 8'h3A};
    vecs[1] = '{8'h55, 1'b0, -1, 1'b0, 8'h3A};
    vecs[2] = '{8'h29, 1'b1, -1, 1'b1, 8'h29};
    vecs[3] = '{8'h3A, 1'b1,  2, 1'b1, GLITCH_EXP};
    vecs[4] = '{8'hFF, 1'b1, -1, 1'b1, 8'hFF};
    vecs[5] = '{8'h00, 1'b1, -1, 1'b1, 8'h00};
    vecs[6] = '{8'h80, 1'b1, -1, 1'b1, 8'h80};
    vecs[7] = '{8'h01, 1'b1, -1, 1'b1, 8'h01};

    repeat (3) @(negedge clk);
    check("reset_data", data, 8'h00);
    check("reset_ready", int'(dataReady), 0);
    check("reset_ferr", int'(frameError), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      clear_log();
      send_frame(vecs[i].tx, vecs[i].stop, vecs[i].glitch, f1);
      if (!vecs[i].stop) begin
        repeat (200) @(negedge clk);
        rx = 1'b1;
      end
      repeat (20) @(negedge clk);
      expect_one($sformatf("vec%0d", i), f1, vecs[i].exp_rdy, vecs[i].exp_data, vecs[i].exp_data);
    end

    // Short low pulse in idle is not a start bit
    clear_log();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch5_count", ev_cyc.size(), 0);
    $display("glitch5: strobes=%0d", ev_cyc.size());
    clear_log();
    send_frame(8'h29, 1'b1, -1, f1);
    repeat (20) @(negedge clk);
    expect_one("after_glitch5", f1, 1'b1, 8'h29, 8'h29);

    // Back-to-back frames, one stop bit each
    clear_log();
    send_frame(8'h3A, 1'b1, -1, f1);
    send_frame(8'h29, 1'b1, -1, f2);
    repeat (20) @(negedge clk);
    check("b2b_count", ev_cyc.size(), 2);
    if (ev_cyc.size() == 2) begin
      check("b2b_latency", ev_cyc[0] - f1, LAT);
      check("b2b_spacing", ev_cyc[1] - ev_cyc[0], FRAME);
      check("b2b_data0", ev_data[0], 8'h3A);
      check("b2b_data1", ev_data[1], 8'h29);
      check("b2b_kind", int'(ev_rdy[0] & ev_rdy[1]), 1);
    end
    $display("b2b: strobes=%0d data=0x%02h", ev_cyc.size(), data);

    // Reset during data bit 3
    rb = 8'h3A;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rx = rb[k];
      repeat (CPB) @(negedge clk);
    end
    rx = rb[3];
    repeat (4) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_rst_data", data, 8'h00);
    check("async_rst_ready", int'(dataReady), 0);
    check("async_rst_ferr", int'(frameError), 0);
    $display("midframe reset: data=0x%02h", data);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    clear_log();
    send_frame(8'h29, 1'b1, -1, f1);
    repeat (20) @(negedge clk);
    expect_one("after_reset", f1, 1'b1, 8'h29, 8'h29);

    // Random frames with random gaps (zero gap means back-to-back)
    clear_log();
    for (int i = 0; i < 24; i++) begin
      int         gap;
      logic [7:0] b;
      gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
      repeat (gap) @(negedge clk);
      b = 8'($urandom);
      send_frame(b, 1'b1, -1, f1);
      exp_cyc.push_back(f1 + LAT);
      exp_b.push_back(b);
    end
    repeat (20) @(negedge clk);
    check("rand_count", ev_cyc.size(), exp_cyc.size());
    for (int i = 0; i < exp_cyc.size() && i < ev_cyc.size(); i++) begin
      check($sformatf("rand%0d_cycle", i), ev_cyc[i], exp_cyc[i]);
      check($sformatf("rand%0d_data", i), ev_data[i], exp_b[i]);
      check($sformatf("rand%0d_kind", i), int'(ev_rdy[i]), 1);
      $display("rand%0d: byte=0x%02h cycle=%0d", i, ev_data[i], ev_cyc[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 frames: it recovers bytes from the asynchronous serial line and presents each one to the consumer with a one-cycle strobe. It is the receive-side counterpart of the existing `uart` transmitter and uses the same clock, reset and `data`/`dataReady` naming. A top level instantiates it beside the transmitter on `clk_50`, driving `reset` from the inverted board reset.

## Interface
- `CLK_HZ`, default 50_000_000, input clock frequency in Hz.
- `BAUD`, default 115200, line rate in bits per second.
- Derived constants:
  - `CLKS_PER_BIT = CLK_HZ / BAUD`, integer division (434 at the defaults).
  - `HALF = CLKS_PER_BIT / 2`.
  - Elaboration fails if `CLKS_PER_BIT < 4`.
- `clk` input 1: the single clock; everything is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `rx` input 1: serial line, asynchronous to `clk`, idles high.
- `data` output 8: last correctly received byte.
- `dataReady` output 1: one-cycle strobe; `data` is new in this cycle.
- `frameError` output 1: one-cycle strobe; the stop bit sampled low.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. Both flops reset to 1.
- LSB first: 1 start bit (0), 8 data bits, 1 stop bit (1). No parity.
- No backpressure: the consumer must capture `data` in the `dataReady` cycle. The next byte may overwrite it.
- Registers: state, bit counter (0..7), cycle counter (sized for `CLKS_PER_BIT-1`) and shift register.
- States and transitions:
  - IDLE: when `rx_s==0`, clear the cycle counter and go to START.
  - START: after HALF cycles, sample the line. If 0, go to DATA with bit index 0. If 1, treat it as a glitch and return to IDLE with no output.
  - DATA: sample every `CLKS_PER_BIT` cycles and shift into bit[index]. After bit 7, go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample the stop bit.
    - If 1: load `data` from the shift register, pulse `dataReady`, go to IDLE.
    - If 0: pulse `frameError`, keep `data` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s==1`, then go to IDLE. This stops a held-low line (break) from producing repeated frames.
  - Unreachable encodings go to IDLE.
- `dataReady` and `frameError` are registered, never asserted together, and never asserted for more than one cycle.
- Reset may arrive mid-frame:
  - All state is discarded immediately.
  - Outputs are forced to reset values.
  - The next byte is received only if its full frame starts after reset deasserts.
- Reset values: `data=8'h00`, `dataReady=0`, `frameError=0`, state IDLE, synchronizer flops 1.

## Timing
- Let cycle E be the first cycle in which IDLE observes `rx_s==0`.
  - The start sample is taken at E+HALF.
  - Data bit k is sampled at E+HALF+(k+1)·`CLKS_PER_BIT`.
  - The stop bit is sampled at E+HALF+9·`CLKS_PER_BIT`.
  - `dataReady`/`frameError` is high in the following cycle.
- From the pin, E trails the `rx` falling edge by 2 cycles (synchronizer).
- IDLE is re-entered in the strobe cycle. A start edge arriving in that cycle is detected at the next edge.
- Back-to-back frames with exactly one stop bit are received with no loss.
- Baud mismatch tolerance comes from mid-bit sampling only; there is no resynchronization within a frame.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- Defined:
  - Each sample point (start, data, stop) takes `rx_s` at the nominal sample cycle −1, at the cycle itself and at +1.
  - The bit value is the 2-of-3 majority.
  - The decision is used at nominal+1, so all outputs shift one cycle later.
  - The START glitch check uses the majority value.
- Undefined: one sample at the nominal cycle; the latencies in Timing are exact.

## Structure
- Package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - the frame constants: data bits = 8, start level 0, stop level 1;
  - a `clks_per_bit(CLK_HZ, BAUD)` function, to be shared with the `uart` transmitter.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with reset value 1. It is used only for `rx`.

## Test plan
All scenarios use `CLK_HZ=1600`, `BAUD=100`, so `CLKS_PER_BIT=16` and `HALF=8`.
- Send 0x3A at the nominal rate:
  - exactly one `dataReady` pulse, in the cycle after the stop sample;
  - `data=8'h3A`, `frameError` stays 0;
  - pulse cycle equals edge + 2 + 8 + 144 + 1 without the macro.
- Drive `rx` low for 5 cycles in IDLE, then high: no strobe, and the receiver returns to IDLE. A following 0x29 frame is received correctly.
- Receive 0x3A, then frame 0x55 with the stop bit driven 0 and `rx` held low for 200 cycles:
  - one `frameError` pulse and no `dataReady`;
  - `data` remains 0x3A;
  - no further strobes until `rx` rises; the next frame 0x29 is received.
- Send 0x3A then 0x29 back-to-back with one stop bit each: two `dataReady` pulses 160 cycles apart, carrying 0x3A then 0x29.
- Assert `reset` during data bit 3 of a frame:
  - `data`, `dataReady` and `frameError` go to 0 asynchronously;
  - after release, a full 0x29 frame yields `data=8'h29`.
- Inject a 1-cycle inverted glitch exactly at the bit 2 sample point of 0x3A:
  - with `UART_RX_MAJORITY_EN`, `data=8'h3A`;
  - without it, `data=8'h3E`.
